// File: rtl/step_ramp_gen.sv
// Trapezoidal step/direction pulse generator: accelerates, slews and decelerates
// a STEPS-pulse move; degrades to a triangular profile on short moves.
module step_ramp_gen #(
  parameter int unsigned STEP_W    = 16,
  parameter int unsigned PER_W     = 16,
  parameter int unsigned PULSE_W   = 100,
  parameter int unsigned DIR_SETUP = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              DIR_IN,
  input  logic [STEP_W-1:0] STEPS,
  input  logic [PER_W-1:0]  START_PERIOD,
  input  logic [PER_W-1:0]  MIN_PERIOD,
  input  logic [PER_W-1:0]  DPER,
  input  logic              ABORT,
  output logic              STEP_OUT,
  output logic              DIR_OUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ABORTED
);

  localparam int unsigned PW = PER_W + 1;
  localparam int unsigned SW = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;
  localparam logic [PW-1:0] PULSE_LEN  = PW'(PULSE_W);
  localparam logic [PW-1:0] PULSE_MIN  = PW'(PULSE_W + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);

  typedef enum logic [2:0] {IDLE, SETUP, ACCEL, SLEW, DECEL} state_t;

  state_t            state_q, state_d;
  logic              dir_q, dir_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              step_q, step_d;
  logic              abort_seen_q, abort_seen_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [STEP_W-1:0] ramp_q, ramp_d;
  logic [STEP_W-1:0] done_cnt_q, done_cnt_d;
  logic [PW-1:0]     min_q, min_d;
  logic [PW-1:0]     start_q, start_d;
  logic [PW-1:0]     dper_q, dper_d;
  logic [PW-1:0]     per_q, per_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [SW-1:0]     sc_q, sc_d;

  logic [PW-1:0]     eff_min, eff_start, per_up, per_up_sat;
  logic [STEP_W-1:0] done_inc, rem;
  logic              boundary, abort_now;

  always_comb begin
    eff_min    = ({1'b0, MIN_PERIOD} > PULSE_MIN) ? {1'b0, MIN_PERIOD} : PULSE_MIN;
    eff_start  = ({1'b0, START_PERIOD} > eff_min) ? {1'b0, START_PERIOD} : eff_min;
    done_inc   = done_cnt_q + 1'b1;
    rem        = steps_q - done_inc;
    per_up     = per_q + dper_q;
    per_up_sat = (per_up > start_q) ? start_q : per_up;
    boundary   = (pc_q == per_q - PW'(1));
    abort_now  = abort_seen_q | ABORT;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    abort_seen_d = abort_seen_q;
    steps_d      = steps_q;
    ramp_d       = ramp_q;
    done_cnt_d   = done_cnt_q;
    min_d        = min_q;
    start_d      = start_q;
    dper_d       = dper_q;
    per_d        = per_q;
    pc_d         = pc_q;
    sc_d         = sc_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          aborted_d = 1'b0;
          if (STEPS == '0) begin
            done_d = 1'b1;
          end else begin
            steps_d      = STEPS;
            min_d        = eff_min;
            start_d      = eff_start;
            dper_d       = {1'b0, DPER};
            per_d        = eff_start;
            dir_d        = DIR_IN;
            busy_d       = 1'b1;
            ramp_d       = '0;
            done_cnt_d   = '0;
            pc_d         = '0;
            sc_d         = '0;
            abort_seen_d = 1'b0;
            state_d      = (DIR_SETUP == 0) ? ACCEL : SETUP;
          end
        end
      end
      SETUP: begin
        // No pulse has been issued yet, so an abort here ends the move at once.
        if (ABORT) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (sc_q == SETUP_LAST) begin
          state_d = ACCEL;
          pc_d    = '0;
        end else begin
          sc_d = sc_q + 1'b1;
        end
      end
      default: begin
        abort_seen_d = abort_now;
        if (!boundary) begin
          pc_d = pc_q + 1'b1;
        end else begin
          pc_d         = '0;
          done_cnt_d   = done_inc;
          abort_seen_d = 1'b0;
          if (rem == '0 || abort_now) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            aborted_d = (rem != '0);
          end else if (state_q == DECEL) begin
            per_d = per_up_sat;
          end else if (rem <= ramp_q) begin
            state_d = DECEL;
            per_d   = per_up_sat;
          end else if (state_q == ACCEL) begin
            ramp_d = ramp_q + 1'b1;
            if (per_q <= min_q + dper_q) begin
              state_d = SLEW;
              per_d   = min_q;
            end else begin
              per_d = per_q - dper_q;
            end
          end
        end
      end
    endcase

    step_d = (state_d == ACCEL || state_d == SLEW || state_d == DECEL) && (pc_d < PULSE_LEN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      step_q       <= 1'b0;
      abort_seen_q <= 1'b0;
      steps_q      <= '0;
      ramp_q       <= '0;
      done_cnt_q   <= '0;
      min_q        <= '0;
      start_q      <= '0;
      dper_q       <= '0;
      per_q        <= '0;
      pc_q         <= '0;
      sc_q         <= '0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      step_q       <= step_d;
      abort_seen_q <= abort_seen_d;
      steps_q      <= steps_d;
      ramp_q       <= ramp_d;
      done_cnt_q   <= done_cnt_d;
      min_q        <= min_d;
      start_q      <= start_d;
      dper_q       <= dper_d;
      per_q        <= per_d;
      pc_q         <= pc_d;
      sc_q         <= sc_d;
    end
  end

  assign STEP_OUT = step_q;
  assign DIR_OUT  = dir_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ABORTED  = aborted_q;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench: dut_a (PULSE_W=2, no DIR setup) for profile shapes,
// dut_b (PULSE_W=100, DIR_SETUP=32) for setup delay, clamping and async reset.
`timescale 1ns/1ps
module tb_step_ramp_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        a_rst_n, a_start, a_dir_in, a_abort;
  logic [15:0] a_steps, a_sp, a_mp, a_dp;
  logic        a_step, a_dir, a_busy, a_done, a_aborted;

  logic        b_rst_n, b_start, b_dir_in, b_abort;
  logic [15:0] b_steps, b_sp, b_mp, b_dp;
  logic        b_step, b_dir, b_busy, b_done, b_aborted;

  step_ramp_gen #(.STEP_W(16), .PER_W(16), .PULSE_W(2), .DIR_SETUP(0)) dut_a (
    .CLK(clk), .RST_N(a_rst_n), .START(a_start), .DIR_IN(a_dir_in), .STEPS(a_steps),
    .START_PERIOD(a_sp), .MIN_PERIOD(a_mp), .DPER(a_dp), .ABORT(a_abort),
    .STEP_OUT(a_step), .DIR_OUT(a_dir), .BUSY(a_busy), .DONE(a_done), .ABORTED(a_aborted)
  );

  step_ramp_gen #(.STEP_W(16), .PER_W(16), .PULSE_W(100), .DIR_SETUP(32)) dut_b (
    .CLK(clk), .RST_N(b_rst_n), .START(b_start), .DIR_IN(b_dir_in), .STEPS(b_steps),
    .START_PERIOD(b_sp), .MIN_PERIOD(b_mp), .DPER(b_dp), .ABORT(b_abort),
    .STEP_OUT(b_step), .DIR_OUT(b_dir), .BUSY(b_busy), .DONE(b_done), .ABORTED(b_aborted)
  );

  int   rise_cyc[16];
  int   n_rise, high_cnt, busy_cnt, done_cyc;
  logic aborted_at_done;

  // Cycle 0 carries START; cycle c is sampled at the c-th falling edge after it.
  task automatic run_a(input logic [15:0] steps, input logic [15:0] sp, input logic [15:0] mp,
                       input logic [15:0] dp, input logic dir, input int abort_cyc, input int max_cyc);
    logic prev;
    @(negedge clk);
    a_start = 1'b1; a_steps = steps; a_sp = sp; a_mp = mp; a_dp = dp; a_dir_in = dir;
    n_rise = 0; high_cnt = 0; busy_cnt = 0; done_cyc = -1; aborted_at_done = 1'b0; prev = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      a_start = 1'b0;
      a_abort = (c == abort_cyc);
      if (a_step && !prev && n_rise < 16) begin
        rise_cyc[n_rise] = c;
        n_rise++;
      end
      if (a_step) high_cnt++;
      if (a_busy) busy_cnt++;
      prev = a_step;
      if (a_done) begin
        done_cyc = c;
        aborted_at_done = a_aborted;
        break;
      end
    end
    a_abort = 1'b0;
  endtask

  function automatic int period_of(input int i);
    if (i + 1 < n_rise) return rise_cyc[i + 1] - rise_cyc[i];
    return done_cyc - rise_cyc[i];
  endfunction

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_start = 0; a_dir_in = 0; a_abort = 0; a_steps = 0; a_sp = 0; a_mp = 0; a_dp = 0;
    b_start = 0; b_dir_in = 0; b_abort = 0; b_steps = 0; b_sp = 0; b_mp = 0; b_dp = 0;
    #22;
    n_cmp++;
    if ({a_step, a_dir, a_busy, a_done, a_aborted} !== 5'b0) begin
      n_bad++; $display("FAIL reset_a: outputs=%b want 00000", {a_step, a_dir, a_busy, a_done, a_aborted});
    end
    n_cmp++;
    if ({b_step, b_dir, b_busy, b_done, b_aborted} !== 5'b0) begin
      n_bad++; $display("FAIL reset_b: outputs=%b want 00000", {b_step, b_dir, b_busy, b_done, b_aborted});
    end
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_trapezoid();
    int exp_per[8] = '{10, 8, 6, 4, 4, 6, 8, 10};
    run_a(16'd8, 16'd10, 16'd4, 16'd2, 1'b0, 0, 100);
    n_cmp++;
    if (n_rise !== 8) begin n_bad++; $display("FAIL trap_pulses: got %0d want 8", n_rise); end
    n_cmp++;
    if (done_cyc !== 57) begin n_bad++; $display("FAIL trap_done_cycle: got %0d want 57", done_cyc); end
    n_cmp++;
    if (busy_cnt !== 56) begin n_bad++; $display("FAIL trap_busy_len: got %0d want 56", busy_cnt); end
    n_cmp++;
    if (high_cnt !== 16) begin n_bad++; $display("FAIL trap_high_cycles: got %0d want 16", high_cnt); end
    n_cmp++;
    if (rise_cyc[0] !== 1) begin n_bad++; $display("FAIL trap_first_rise: got %0d want 1", rise_cyc[0]); end
    for (int i = 0; i < 8 && i < n_rise; i++) begin
      n_cmp++;
      if (period_of(i) !== exp_per[i]) begin
        n_bad++; $display("FAIL trap_period[%0d]: got %0d want %0d", i, period_of(i), exp_per[i]);
      end
    end
    n_cmp++;
    if (aborted_at_done !== 1'b0) begin n_bad++; $display("FAIL trap_aborted: got %b want 0", aborted_at_done); end
  endtask

  task automatic test_triangle();
    int exp_per[3] = '{10, 8, 10};
    run_a(16'd3, 16'd10, 16'd4, 16'd2, 1'b0, 0, 60);
    n_cmp++;
    if (n_rise !== 3) begin n_bad++; $display("FAIL tri_pulses: got %0d want 3", n_rise); end
    n_cmp++;
    if (done_cyc !== 29) begin n_bad++; $display("FAIL tri_done_cycle: got %0d want 29", done_cyc); end
    for (int i = 0; i < 3 && i < n_rise; i++) begin
      n_cmp++;
      if (period_of(i) !== exp_per[i]) begin
        n_bad++; $display("FAIL tri_period[%0d]: got %0d want %0d", i, period_of(i), exp_per[i]);
      end
    end
  endtask

  task automatic test_zero_steps();
    run_a(16'd0, 16'd10, 16'd4, 16'd2, 1'b1, 0, 5);
    n_cmp++;
    if (done_cyc !== 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    n_cmp++;
    if (busy_cnt !== 0 || n_rise !== 0) begin
      n_bad++; $display("FAIL zero_no_activity: busy=%0d pulses=%0d want 0/0", busy_cnt, n_rise);
    end
    n_cmp++;
    if (a_dir !== 1'b0) begin n_bad++; $display("FAIL zero_dir_hold: got %b want 0", a_dir); end
  endtask

  task automatic test_abort();
    run_a(16'd8, 16'd10, 16'd4, 16'd2, 1'b0, 26, 100);
    n_cmp++;
    if (n_rise !== 4) begin n_bad++; $display("FAIL abort_pulses: got %0d want 4", n_rise); end
    n_cmp++;
    if (done_cyc !== 29) begin n_bad++; $display("FAIL abort_done_cycle: got %0d want 29", done_cyc); end
    n_cmp++;
    if (high_cnt !== 8) begin n_bad++; $display("FAIL abort_high_cycles: got %0d want 8", high_cnt); end
    n_cmp++;
    if (aborted_at_done !== 1'b1) begin n_bad++; $display("FAIL abort_flag: got %b want 1", aborted_at_done); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_aborted !== 1'b1 || a_done !== 1'b0 || a_step !== 1'b0) begin
      n_bad++; $display("FAIL abort_hold: aborted=%b done=%b step=%b want 1/0/0", a_aborted, a_done, a_step);
    end
  endtask

  task automatic test_const_speed();
    run_a(16'd3, 16'd5, 16'd4, 16'd0, 1'b0, 0, 40);
    n_cmp++;
    if (n_rise !== 3 || done_cyc !== 16) begin
      n_bad++; $display("FAIL const_move: pulses=%0d done=%0d want 3/16", n_rise, done_cyc);
    end
    for (int i = 0; i < 3 && i < n_rise; i++) begin
      n_cmp++;
      if (period_of(i) !== 5) begin n_bad++; $display("FAIL const_period[%0d]: got %0d want 5", i, period_of(i)); end
    end
    n_cmp++;
    if (aborted_at_done !== 1'b0) begin n_bad++; $display("FAIL const_aborted_cleared: got %b want 0", aborted_at_done); end
  endtask

  task automatic test_setup_clamp_reset();
    int   exp_rise[4] = '{33, 153, 263, 364};
    int   rises[4];
    int   nr, first_high, done_seen;
    logic prev;
    nr = 0; first_high = 0; done_seen = 0; prev = 1'b0;
    @(negedge clk);
    b_start = 1'b1; b_dir_in = 1'b1; b_steps = 16'd10; b_sp = 16'd120; b_mp = 16'd50; b_dp = 16'd10;
    for (int c = 1; c <= 370; c++) begin
      @(negedge clk);
      b_start  = (c == 5);
      b_dir_in = 1'b0;
      if (c == 1) begin
        n_cmp++;
        if (b_dir !== 1'b1 || b_busy !== 1'b1) begin
          n_bad++; $display("FAIL setup_cycle1: dir=%b busy=%b want 1/1", b_dir, b_busy);
        end
      end
      if (b_step && !prev && nr < 4) begin rises[nr] = c; nr++; end
      if (b_step && c < 153) first_high++;
      if (b_done) done_seen++;
      prev = b_step;
    end
    n_cmp++;
    if (nr !== 4) begin n_bad++; $display("FAIL setup_rise_count: got %0d want 4", nr); end
    for (int i = 0; i < 4 && i < nr; i++) begin
      n_cmp++;
      if (rises[i] !== exp_rise[i]) begin
        n_bad++; $display("FAIL setup_rise[%0d]: got cycle %0d want %0d", i, rises[i], exp_rise[i]);
      end
    end
    n_cmp++;
    if (first_high !== 100) begin n_bad++; $display("FAIL pulse_width: got %0d want 100", first_high); end
    n_cmp++;
    if (b_dir !== 1'b1 || done_seen !== 0 || b_step !== 1'b1) begin
      n_bad++; $display("FAIL busy_start_ignored: dir=%b done=%0d step=%b want 1/0/1", b_dir, done_seen, b_step);
    end
    b_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b_step, b_busy, b_dir} !== 3'b000) begin
      n_bad++; $display("FAIL async_reset: step/busy/dir=%b want 000", {b_step, b_busy, b_dir});
    end
    repeat (2) @(negedge clk);
    b_rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b_done || b_busy || b_step) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin n_bad++; $display("FAIL reset_no_done: active cycles=%0d want 0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_trapezoid();
    test_triangle();
    test_zero_steps();
    test_abort();
    test_const_speed();
    test_setup_clamp_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
